// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bus: source A (pipeline), source B (long-latency unit)
// and the registered register-file write port.
// Optional macro RF_WB_PEND_MASK_EN adds the pend_mask signal.
interface rf_wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    // Source A: pipeline writeback, unbuffered
    logic            a_valid;
    logic [4:0]      a_addr;
    logic [31:0]     a_data;
    logic            a_stall;

    // Source B: long-latency unit, valid/ready into the FIFO
    logic            b_valid;
    logic [4:0]      b_addr;
    logic [31:0]     b_data;
    logic            b_ready;

    // Register-file write port
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;

    logic [CntW-1:0] fifo_cnt;

`ifdef RF_WB_PEND_MASK_EN
    logic [31:0]     pend_mask;
`endif

    // Requesters and register file side
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_stall, b_ready, wr_en, wr_addr, wr_data, fifo_cnt
`ifdef RF_WB_PEND_MASK_EN
        , input pend_mask
`endif
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_stall, b_ready, wr_en, wr_addr, wr_data, fifo_cnt
`ifdef RF_WB_PEND_MASK_EN
        , output pend_mask
`endif
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline writeback (A, priority, unbuffered) and the long-latency unit
// (B, buffered in a DEPTH-entry FIFO). A starvation counter forces a B write
// once the FIFO head has waited MAX_WAIT cycles. Write port is registered.
// Optional macro RF_WB_PEND_MASK_EN adds pend_mask (pending-write interlock).
module rf_wb_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CW       = 8
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned     PtrW    = $clog2(DEPTH);
    localparam int unsigned     CntW    = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CW-1:0]   MaxWait = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        GntIdle,
        GntA,
        GntB,
        GntForceB
    } grant_e;

    // FIFO storage and pointers
    logic [4:0]      fifo_addr_q [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Starvation counter
    logic [CW-1:0]   starve_q, starve_d;

    // Registered write port
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;

    grant_e          grant;
    logic            fifo_empty;
    logic            fifo_full;
    logic            force_b;
    logic            push;
    logic            pop;
    logic [4:0]      head_addr;
    logic [31:0]     head_data;
    logic [4:0]      sel_addr;
    logic [31:0]     sel_data;

    // FIFO status, head entry and the B-side handshake.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == FullCnt);
        head_addr  = fifo_addr_q[rptr_q];
        head_data  = fifo_data_q[rptr_q];
        // A full FIFO refuses B even when it pops this cycle.
        push       = bus.b_valid && !fifo_full;
    end

    // Priority grant: forced B, then A, then B, else idle.
    always_comb begin
        grant   = GntIdle;
        force_b = !fifo_empty && (starve_q == MaxWait);
        if (force_b) begin
            grant = GntForceB;
        end else if (bus.a_valid) begin
            grant = GntA;
        end else if (!fifo_empty) begin
            grant = GntB;
        end
    end

    // Select the granted source and decide whether the FIFO pops.
    always_comb begin
        pop      = 1'b0;
        sel_addr = bus.a_addr;
        sel_data = bus.a_data;
        case (grant)
            GntForceB, GntB: begin
                pop      = 1'b1;
                sel_addr = head_addr;
                sel_data = head_data;
            end
            default: ;
        endcase
    end

    // Next write-port state; r0 grants are consumed but never written.
    always_comb begin
        wr_en_d   = (grant != GntIdle) && (sel_addr != 5'd0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Address/data only move on a real write so idle cycles hold them.
        if (wr_en_d) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // FIFO pointer and occupancy update; pointers wrap as DEPTH is a power of 2.
    always_comb begin
        wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: ;
        endcase
    end

    // Starvation counter: counts cycles the head waits, saturating at MAX_WAIT.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != MaxWait) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Control state and write-port registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage; contents are qualified by cnt_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= bus.b_addr;
            fifo_data_q[wptr_q] <= bus.b_data;
        end
    end

    assign bus.a_stall  = bus.a_valid && force_b;
    assign bus.b_ready  = !fifo_full;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.fifo_cnt = cnt_q;

`ifdef RF_WB_PEND_MASK_EN
    logic [31:0] pend_mask;

    // Registers with a write still queued in the FIFO or sitting in the output stage.
    always_comb begin
        logic [PtrW-1:0] idx;
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PtrW'(i);
            if (CntW'(i) < cnt_q) begin
                pend_mask[fifo_addr_q[idx]] = 1'b1;
            end
        end
        if (wr_en_q) begin
            pend_mask[wr_addr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign bus.pend_mask = pend_mask;
`endif
endmodule
